// File: rtl/alu_pkg.sv
// Shared ALU op encodings and arbiter FSM state for the alu_arbiter slice.
// Consumed by the ALU, the handshake interface and the arbiter top.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_ctrl_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Per-requester request/response handshake bundle for alu_arbiter.
// master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
  parameter int LEN = 32
) ();
  import alu_pkg::*;

  logic           req_valid;
  logic           req_ready;
  logic [LEN-1:0] op1;
  logic [LEN-1:0] op2;
  alu_ctrl_e      ctrl;
  logic           resp_valid;
  logic           resp_ready;
  logic [LEN-1:0] result;
  logic           zero;

  modport master (
    output req_valid, op1, op2, ctrl,
    output resp_ready,
    input  req_ready,
    input  resp_valid, result, zero
  );

  modport slave (
    input  req_valid, op1, op2, ctrl,
    input  resp_ready,
    output req_ready,
    output resp_valid, result, zero
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational LEN-bit ALU shared by both arbiter requesters.
// Shift amounts use the low log2(LEN) bits of b; SLT is signed.
module alu_arbiter_alu
  import alu_pkg::*;
#(
  parameter int LEN = 32
) (
  input  alu_ctrl_e      ctrl,
  input  logic [LEN-1:0] a,
  input  logic [LEN-1:0] b,
  output logic [LEN-1:0] y
);

  localparam int SW = $clog2(LEN);

  logic [SW-1:0] sh;
  logic          lt;

  assign sh = b[SW-1:0];
  assign lt = $signed(a) < $signed(b);

  always_comb begin
    y = '0;
    unique case (ctrl)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLT: y = {{(LEN-1){1'b0}}, lt};
      ALU_SLL: y = a << sh;
      ALU_SRL: y = a >> sh;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Define ALU_ARB_PERF_CNT_EN to build the per-requester grant counters.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  alu_arbiter_if.slave req0,
  alu_arbiter_if.slave req1,
  output logic [31:0] grant_cnt0,
  output logic [31:0] grant_cnt1
);

  arb_state_e     state;
  logic           last;
  logic           rv0, rv1;
  logic [LEN-1:0] res0, res1;
  logic           z0, z1;

  logic           hs0, hs1, free;
  logic           gnt0, gnt1;
  logic           rdy0, rdy1;
  logic           acc0, acc1;
  alu_ctrl_e      alu_ctrl;
  logic [LEN-1:0] alu_a, alu_b, alu_y;
  logic           alu_z;

  assign hs0  = rv0 && req0.resp_ready;
  assign hs1  = rv1 && req1.resp_ready;
  assign free = (state == ST_IDLE) || hs0 || hs1;

  // Grant never looks at the requester's own valid: no valid->ready path.
  assign gnt0 = !req1.req_valid || last;
  assign gnt1 = !req0.req_valid || !last;

  assign rdy0 = !rst && free && gnt0;
  assign rdy1 = !rst && free && gnt1;
  assign acc0 = req0.req_valid && rdy0;
  assign acc1 = req1.req_valid && rdy1;

  assign alu_ctrl = acc1 ? req1.ctrl : req0.ctrl;
  assign alu_a    = acc1 ? req1.op1  : req0.op1;
  assign alu_b    = acc1 ? req1.op2  : req0.op2;
  assign alu_z    = (alu_y == '0);

  alu_arbiter_alu #(
    .LEN (LEN)
  ) u_alu (
    .ctrl (alu_ctrl),
    .a    (alu_a),
    .b    (alu_b),
    .y    (alu_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      last  <= 1'b1;
      rv0   <= 1'b0;
      rv1   <= 1'b0;
      res0  <= '0;
      res1  <= '0;
      z0    <= 1'b0;
      z1    <= 1'b0;
    end else begin
      if (acc0) begin
        rv0  <= 1'b1;
        res0 <= alu_y;
        z0   <= alu_z;
        last <= 1'b0;
      end else if (hs0) begin
        rv0  <= 1'b0;
      end
      if (acc1) begin
        rv1  <= 1'b1;
        res1 <= alu_y;
        z1   <= alu_z;
        last <= 1'b1;
      end else if (hs1) begin
        rv1  <= 1'b0;
      end
      unique case (state)
        ST_IDLE:
          if (acc0 || acc1)
            state <= ST_BUSY;
        ST_BUSY:
          if ((hs0 || hs1) && !(acc0 || acc1))
            state <= ST_IDLE;
      endcase
    end
  end

  assign req0.req_ready  = rdy0;
  assign req1.req_ready  = rdy1;
  assign req0.resp_valid = rv0;
  assign req1.resp_valid = rv1;
  assign req0.result     = res0;
  assign req1.result     = res1;
  assign req0.zero       = z0;
  assign req1.zero       = z1;

`ifdef ALU_ARB_PERF_CNT_EN
  logic [31:0] cnt0, cnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (acc0) cnt0 <= cnt0 + 32'd1;
      if (acc1) cnt1 <= cnt1 + 32'd1;
    end
  end

  assign grant_cnt0 = cnt0;
  assign grant_cnt1 = cnt1;
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table plus tie, backpressure,
// streaming, mid-flight reset and grant-counter sequences.
module tb_alu_arbiter;
  import alu_pkg::*;

  typedef struct {
    int          r;
    alu_ctrl_e   c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        z;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] gc0, gc1;
  int          n_chk = 0;
  int          n_err = 0;
  int          exp_cnt0 = 0;
  int          exp_cnt1 = 0;
  vec_t        vecs[10];

  alu_arbiter_if #(.LEN(32)) i0 ();
  alu_arbiter_if #(.LEN(32)) i1 ();

  alu_arbiter #(
    .LEN (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (i0),
    .req1       (i1),
    .grant_cnt0 (gc0),
    .grant_cnt1 (gc1)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic set_req(int r, logic v, alu_ctrl_e c,
                         logic [31:0] a, logic [31:0] b);
    if (r == 0) begin
      i0.req_valid = v;
      i0.ctrl = c;
      i0.op1 = a;
      i0.op2 = b;
    end else begin
      i1.req_valid = v;
      i1.ctrl = c;
      i1.op1 = a;
      i1.op2 = b;
    end
  endtask

  function automatic logic rdy(int r);
    return (r == 0) ? i0.req_ready : i1.req_ready;
  endfunction

  function automatic logic rv(int r);
    return (r == 0) ? i0.resp_valid : i1.resp_valid;
  endfunction

  function automatic logic [31:0] res(int r);
    return (r == 0) ? i0.result : i1.result;
  endfunction

  function automatic logic zz(int r);
    return (r == 0) ? i0.zero : i1.zero;
  endfunction

  function automatic logic [31:0] exp_gc(int n);
`ifdef ALU_ARB_PERF_CNT_EN
    return n;
`else
    return (n == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  // req0 adds 3+4=7, req1 subs 10-4=6; grants must alternate.
  task automatic stream(int n, int first);
    set_req(0, 1'b1, ALU_ADD, 32'd3, 32'd4);
    set_req(1, 1'b1, ALU_SUB, 32'd10, 32'd4);
    i0.resp_ready = 1'b1;
    i1.resp_ready = 1'b1;
    #2;
    for (int i = 0; i < n; i++) begin
      int g;
      g = (first + i) % 2;
      chk("stream_ready", 32'(rdy(g)), 32'd1);
      chk("stream_other_ready", 32'(rdy(1 - g)), 32'd0);
      if (g == 0) exp_cnt0++;
      else exp_cnt1++;
      tick();
      #2;
      chk("stream_valid", 32'(rv(g)), 32'd1);
      chk("stream_other_valid", 32'(rv(1 - g)), 32'd0);
      chk("stream_result", res(g),
          (g == 0) ? 32'd7 : 32'd6);
    end
    set_req(0, 1'b0, ALU_ADD, 32'd0, 32'd0);
    set_req(1, 1'b0, ALU_ADD, 32'd0, 32'd0);
    tick();
    #2;
    chk("stream_drain0", 32'(i0.resp_valid), 32'd0);
    chk("stream_drain1", 32'(i1.resp_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{0, ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0};
    vecs[1] = '{1, ALU_SUB, 32'd9, 32'd9, 32'd0, 1'b1};
    vecs[2] = '{0, ALU_AND, 32'hF0, 32'h3C, 32'h30, 1'b0};
    vecs[3] = '{1, ALU_OR, 32'hF0, 32'h0F, 32'hFF, 1'b0};
    vecs[4] = '{0, ALU_XOR, 32'hFF, 32'hFF, 32'h0, 1'b1};
    vecs[5] = '{1, ALU_SLT, 32'hFFFFFFFD, 32'd2, 32'd1, 1'b0};
    vecs[6] = '{0, ALU_SLL, 32'd1, 32'd4, 32'd16, 1'b0};
    vecs[7] = '{1, ALU_SRL, 32'h80000000, 32'd31, 32'd1, 1'b0};
    vecs[8] = '{0, ALU_ADD, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1};
    vecs[9] = '{1, ALU_SLT, 32'd2, 32'hFFFFFFFD, 32'd0, 1'b1};

    rst = 1'b1;
    i0.resp_ready = 1'b0;
    i1.resp_ready = 1'b0;
    set_req(0, 1'b1, ALU_ADD, 32'd0, 32'd0);
    set_req(1, 1'b1, ALU_ADD, 32'd0, 32'd0);
    tick();
    #2;
    chk("rst_ready0", 32'(i0.req_ready), 32'd0);
    chk("rst_ready1", 32'(i1.req_ready), 32'd0);
    tick();
    set_req(0, 1'b0, ALU_ADD, 32'd0, 32'd0);
    set_req(1, 1'b0, ALU_ADD, 32'd0, 32'd0);
    rst = 1'b0;
    #2;
    chk("rst_valid0", 32'(i0.resp_valid), 32'd0);
    chk("rst_valid1", 32'(i1.resp_valid), 32'd0);
    chk("rst_result0", i0.result, 32'd0);
    chk("rst_result1", i1.result, 32'd0);
    chk("rst_zero0", 32'(i0.zero), 32'd0);
    chk("rst_zero1", 32'(i1.zero), 32'd0);
    chk("rst_cnt0", gc0, 32'd0);
    chk("rst_cnt1", gc1, 32'd0);
    tick();

    // Tie straight out of reset: req0 first, then req1.
    set_req(0, 1'b1, ALU_SUB, 32'd9, 32'd9);
    set_req(1, 1'b1, ALU_OR, 32'hF0, 32'h0F);
    i0.resp_ready = 1'b1;
    i1.resp_ready = 1'b1;
    #2;
    chk("tie_ready0", 32'(i0.req_ready), 32'd1);
    chk("tie_ready1", 32'(i1.req_ready), 32'd0);
    exp_cnt0++;
    tick();
    i0.req_valid = 1'b0;
    #2;
    chk("tie_valid0", 32'(i0.resp_valid), 32'd1);
    chk("tie_result0", i0.result, 32'd0);
    chk("tie_zero0", 32'(i0.zero), 32'd1);
    chk("tie_valid1_early", 32'(i1.resp_valid), 32'd0);
    chk("tie_ready1_b2b", 32'(i1.req_ready), 32'd1);
    exp_cnt1++;
    tick();
    i1.req_valid = 1'b0;
    #2;
    chk("tie_valid1", 32'(i1.resp_valid), 32'd1);
    chk("tie_result1", i1.result, 32'hFF);
    chk("tie_zero1", 32'(i1.zero), 32'd0);
    chk("tie_valid0_done", 32'(i0.resp_valid), 32'd0);
    tick();
    #2;
    chk("tie_idle1", 32'(i1.resp_valid), 32'd0);

    foreach (vecs[k]) begin
      int r;
      r = vecs[k].r;
      set_req(r, 1'b1, vecs[k].c, vecs[k].a, vecs[k].b);
      #2;
      chk("vec_ready", 32'(rdy(r)), 32'd1);
      if (r == 0) exp_cnt0++;
      else exp_cnt1++;
      tick();
      set_req(r, 1'b0, ALU_ADD, 32'd0, 32'd0);
      #2;
      chk("vec_valid", 32'(rv(r)), 32'd1);
      chk("vec_other_valid", 32'(rv(1 - r)), 32'd0);
      chk("vec_result", res(r), vecs[k].y);
      chk("vec_zero", 32'(zz(r)), 32'(vecs[k].z));
      tick();
      #2;
      chk("vec_valid_drop", 32'(rv(r)), 32'd0);
      chk("vec_result_hold", res(r), vecs[k].y);
    end

    // Backpressure on resp1 while both requesters push new work.
    i1.resp_ready = 1'b0;
    set_req(1, 1'b1, ALU_SLT, 32'hFFFFFFFD, 32'd2);
    #2;
    chk("bp_ready1", 32'(i1.req_ready), 32'd1);
    exp_cnt1++;
    tick();
    set_req(1, 1'b1, ALU_ADD, 32'd100, 32'd200);
    set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd1);
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("bp_valid1", 32'(i1.resp_valid), 32'd1);
      chk("bp_result1", i1.result, 32'd1);
      chk("bp_zero1", 32'(i1.zero), 32'd0);
      chk("bp_ready0", 32'(i0.req_ready), 32'd0);
      chk("bp_ready1_hold", 32'(i1.req_ready), 32'd0);
      tick();
    end
    i1.resp_ready = 1'b1;
    #2;
    chk("bp_rel_ready0", 32'(i0.req_ready), 32'd1);
    chk("bp_rel_ready1", 32'(i1.req_ready), 32'd0);
    exp_cnt0++;
    tick();
    set_req(0, 1'b0, ALU_ADD, 32'd0, 32'd0);
    set_req(1, 1'b0, ALU_ADD, 32'd0, 32'd0);
    #2;
    chk("bp_next_valid0", 32'(i0.resp_valid), 32'd1);
    chk("bp_next_result0", i0.result, 32'd2);
    chk("bp_valid1_done", 32'(i1.resp_valid), 32'd0);
    chk("bp_result1_keep", i1.result, 32'd1);
    tick();
    #2;
    chk("bp_idle0", 32'(i0.resp_valid), 32'd0);

    // Last grant was req0, so streaming starts with req1.
    stream(4, 1);

    // Reset with a req1 response pending and undelivered.
    i1.resp_ready = 1'b0;
    set_req(1, 1'b1, ALU_SLL, 32'd1, 32'd4);
    #2;
    chk("mf_ready1", 32'(i1.req_ready), 32'd1);
    exp_cnt1++;
    tick();
    set_req(0, 1'b1, ALU_ADD, 32'd2, 32'd2);
    set_req(1, 1'b1, ALU_ADD, 32'd2, 32'd2);
    rst = 1'b1;
    #2;
    chk("mf_rst_ready0", 32'(i0.req_ready), 32'd0);
    chk("mf_rst_ready1", 32'(i1.req_ready), 32'd0);
    chk("pre_rst_cnt0", gc0, exp_gc(exp_cnt0));
    chk("pre_rst_cnt1", gc1, exp_gc(exp_cnt1));
    tick();
    set_req(0, 1'b0, ALU_ADD, 32'd0, 32'd0);
    set_req(1, 1'b0, ALU_ADD, 32'd0, 32'd0);
    rst = 1'b0;
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    #2;
    chk("mf_valid1", 32'(i1.resp_valid), 32'd0);
    chk("mf_result1", i1.result, 32'd0);
    chk("mf_cnt0", gc0, 32'd0);
    chk("mf_cnt1", gc1, 32'd0);

    // Pointer back at reset value: req0 wins; 3 vs 2 accepts.
    stream(5, 0);
    chk("cnt0_final", gc0, exp_gc(exp_cnt0));
    chk("cnt1_final", gc1, exp_gc(exp_cnt1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
